// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) arbiter serialising transactions onto one memory port,
// with a watchdog abort. Define ARB_ROUND_ROBIN_EN for round-robin ties (default: dcache priority).
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        grant_d,
    output logic        err_timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] wd_cnt;
    logic          pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;
`endif

    // NOTE: pick_d gets a default before any conditional override so no latch is inferred.
    always_comb begin
        pick_d = d_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) pick_d = !last_d;
`endif
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            wd_cnt      <= '0;
            i_ready     <= 1'b0;
            i_rdata     <= '0;
            d_ready     <= 1'b0;
            d_rdata     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            grant_d     <= 1'b0;
            err_timeout <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d      <= 1'b1;  // icache wins the first tie after reset
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        state   <= S_MEM;
                        busy    <= 1'b1;
                        mem_req <= 1'b1;
                        grant_d <= pick_d;
                        wd_cnt  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d  <= pick_d;
`endif
                        if (pick_d) begin
                            mem_addr  <= d_addr & ~32'h3;
                            mem_we    <= d_we;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_addr  <= i_addr & ~32'h3;
                            mem_we    <= 1'b0;
                            mem_wdata <= '0;
                        end
                    end
                end

                S_MEM: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= S_RESP;
                        if (grant_d) begin
                            d_ready <= 1'b1;
                            d_rdata <= mem_we ? '0 : mem_rdata;
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                    end else begin
                        if (wd_cnt != CNT_MAX) wd_cnt <= wd_cnt + 1'b1;
                        // Counter reaches TIMEOUT at this edge: abandon the transaction.
                        if (wd_cnt >= CNT_LAST) begin
                            mem_req     <= 1'b0;
                            err_timeout <= 1'b1;
                            state       <= S_RESP;
                            if (grant_d) begin
                                d_ready <= 1'b1;
                                d_rdata <= '0;
                            end else begin
                                i_ready <= 1'b1;
                                i_rdata <= '0;
                            end
                        end
                    end
                end

                S_RESP: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT=4); honours ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        grant_d;
    logic        err_timeout;

    int n_checks = 0;
    int n_errors = 0;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic FIRST_D = 1'b0;
`else
    localparam logic FIRST_D = 1'b1;
`endif

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ready    (i_ready),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .grant_d    (grant_d),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        tick();
    endtask

    initial begin
        // ---- reset state ----
        apply_reset();
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_i_ready", i_ready, 0);
        check("rst_d_ready", d_ready, 0);
        check("rst_err", err_timeout, 0);
        check("rst_grant_d", grant_d, 0);

        // ---- single icache read, zero wait states ----
        i_req = 1'b1; i_addr = 32'h0040_0004;
        tick();  // cycle 1
        check("t1_mem_req", mem_req, 1);
        check("t1_mem_addr", mem_addr, 32'h0040_0004);
        check("t1_mem_we", mem_we, 0);
        check("t1_grant_d", grant_d, 0);
        check("t1_busy", busy, 1);
        check("t1_i_ready_c1", i_ready, 0);
        mem_ready = 1'b1; mem_rdata = 32'h8C08_0000;
        tick();  // cycle 2
        mem_ready = 1'b0;
        check("t1_i_ready_c2", i_ready, 1);
        check("t1_i_rdata", i_rdata, 32'h8C08_0000);
        check("t1_mem_req_c2", mem_req, 0);
        check("t1_d_ready_c2", d_ready, 0);
        i_req = 1'b0;
        tick();  // cycle 3
        check("t1_i_ready_c3", i_ready, 0);
        check("t1_busy_c3", busy, 0);
        check("t1_i_rdata_hold", i_rdata, 32'h8C08_0000);

        // ---- simultaneous requests ----
        apply_reset();
        i_req = 1'b1; i_addr = 32'h0040_0010;
        d_req = 1'b1; d_addr = 32'h1001_0000; d_we = 1'b0;
        tick();
        check("t2_grant_first", grant_d, FIRST_D);
        check("t2_addr_first", mem_addr, FIRST_D ? 32'h1001_0000 : 32'h0040_0010);
        mem_ready = 1'b1; mem_rdata = FIRST_D ? 32'h1111_1111 : 32'h2222_2222;
        tick();
        mem_ready = 1'b0;
        check("t2_d_ready_first", d_ready, FIRST_D);
        check("t2_i_ready_first", i_ready, !FIRST_D);
        if (FIRST_D) d_req = 1'b0; else i_req = 1'b0;
        tick();  // IDLE: loser still requesting
        check("t2_busy_idle", busy, 0);
        tick();
        check("t2_grant_second", grant_d, !FIRST_D);
        check("t2_addr_second", mem_addr, FIRST_D ? 32'h0040_0010 : 32'h1001_0000);
        mem_ready = 1'b1; mem_rdata = FIRST_D ? 32'h2222_2222 : 32'h1111_1111;
        tick();
        mem_ready = 1'b0;
        check("t2_d_ready_second", d_ready, !FIRST_D);
        check("t2_i_ready_second", i_ready, FIRST_D);
        check("t2_i_rdata", i_rdata, 32'h2222_2222);
        check("t2_d_rdata", d_rdata, 32'h1111_1111);
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // ---- dcache write with 3 wait states ----
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0008; d_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("t3_mem_req_c%0d", c), mem_req, 1);
            check($sformatf("t3_mem_we_c%0d", c), mem_we, 1);
            check($sformatf("t3_wdata_c%0d", c), mem_wdata, 32'hDEAD_BEEF);
            check($sformatf("t3_addr_c%0d", c), mem_addr, 32'h1001_0008);
            check($sformatf("t3_d_ready_c%0d", c), d_ready, 0);
            if (c == 4) begin
                mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
            end
        end
        tick();
        mem_ready = 1'b0;
        check("t3_d_ready", d_ready, 1);
        check("t3_d_rdata", d_rdata, 0);
        check("t3_mem_req_off", mem_req, 0);
        d_req = 1'b0; d_we = 1'b0;
        tick();

        // ---- unaligned dcache read ----
        d_req = 1'b1; d_addr = 32'h0040_0007;
        tick();
        check("t6_mem_addr", mem_addr, 32'h0040_0004);
        check("t6_mem_we", mem_we, 0);
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ready = 1'b0;
        check("t6_d_rdata", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0;
        tick();

        // ---- watchdog: TIMEOUT=4, memory never answers ----
        i_req = 1'b1; i_addr = 32'h0040_0020;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("t4_mem_req_c%0d", c), mem_req, 1);
            check($sformatf("t4_err_c%0d", c), err_timeout, 0);
            check($sformatf("t4_i_ready_c%0d", c), i_ready, 0);
        end
        tick();
        check("t4_mem_req_drop", mem_req, 0);
        check("t4_i_ready", i_ready, 1);
        check("t4_i_rdata", i_rdata, 0);
        check("t4_err", err_timeout, 1);
        i_req = 1'b0;
        tick();
        check("t4_i_ready_off", i_ready, 0);
        i_req = 1'b1; i_addr = 32'h0040_0024;
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h0000_ABCD;
        tick();
        mem_ready = 1'b0;
        check("t4_ok_rdata", i_rdata, 32'h0000_ABCD);
        check("t4_err_sticky", err_timeout, 1);
        i_req = 1'b0;
        tick();

        // ---- stray mem_ready while idle is ignored ----
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ready = 1'b0;
        check("t7_busy", busy, 0);
        check("t7_i_ready", i_ready, 0);
        check("t7_d_ready", d_ready, 0);
        tick();
        check("t7_i_rdata", i_rdata, 32'h0000_ABCD);

        // ---- reset in the second MEM cycle ----
        d_req = 1'b1; d_addr = 32'h1001_0040;
        tick();  // MEM cycle 1
        tick();  // MEM cycle 2
        check("t5_mem_req_pre", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        check("t5_mem_req", mem_req, 0);
        check("t5_busy", busy, 0);
        check("t5_err", err_timeout, 0);
        check("t5_d_ready", d_ready, 0);
        d_req = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("t5_idle_busy_%0d", c), busy, 0);
            check($sformatf("t5_idle_mem_req_%0d", c), mem_req, 0);
            check($sformatf("t5_idle_d_ready_%0d", c), d_ready, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single main-memory port in the MIPS pipeline with caches. It accepts miss/fill reads from the instruction cache and read/write transactions from the data cache, and serialises them onto one memory request/ready handshake. Each requester gets a one-cycle response pulse carrying the returned word. A watchdog aborts memory transactions that never complete and raises a sticky error.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles in MEM waiting for `mem_ready` before abort. Must be ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset: asserted when 0.
- `i_req`  in  1  icache read request; held until `i_ready`.
- `i_addr`  in  32  icache byte address; stable while `i_req`.
- `i_ready`  out  1  one-cycle response pulse to icache.
- `i_rdata`  out  32  word returned to icache; valid with `i_ready`.
- `d_req`  in  1  dcache request; held until `d_ready`.
- `d_we`  in  1  dcache write (1) / read (0).
- `d_addr`  in  32  dcache byte address.
- `d_wdata`  in  32  dcache write data.
- `d_ready`  out  1  one-cycle response pulse to dcache.
- `d_rdata`  out  32  word returned to dcache; 0 for writes.
- `mem_req`  out  1  memory request; held until `mem_ready` or abort.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  32  word-aligned memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data; sampled when `mem_ready`=1.
- `mem_ready`  in  1  memory completion, single cycle.
- `busy`  out  1  1 in any state other than IDLE.
- `grant_d`  out  1  owner of the current or last transaction: 1 = dcache, 0 = icache.
- `err_timeout`  out  1  sticky watchdog error.

## Operation
- FSM has three states: IDLE, MEM, RESP.
- **IDLE:**
  - If any request is active, choose a winner and latch its addr/we/wdata into `mem_*`.
  - `mem_addr` = `{addr[31:2],2'b00}`; `mem_we` = `d_we` for dcache, 0 for icache.
  - Set `mem_req`=1 and `grant_d`, clear the watchdog counter, go to MEM.
- **MEM:**
  - `mem_*` outputs are held constant.
  - On `mem_ready`=1: capture `mem_rdata`, or 0 for writes, into the winner's `x_rdata`; drop `mem_req`; go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`: drop `mem_req`, set `err_timeout`, load `x_rdata`=0, go to RESP.
- **RESP:** pulse the winner's `x_ready` for exactly one cycle, then return to IDLE. Requests are not sampled in RESP.
- Requester contract: deassert `req` at the clock edge ending its `x_ready` cycle. A `req` still high in the following IDLE cycle is treated as a new request.
- `x_rdata` holds its value until the next response to that requester.
- Counter width is `$clog2(TIMEOUT+1)` and it saturates.
- `err_timeout` clears only on reset.
- `mem_req` and `mem_ready` are never both sampled in IDLE or RESP. A `mem_ready` arriving outside MEM is ignored.

## Timing
- Every output resets to 0, asynchronously and immediately.
- Reset in mid-transaction:
  - `mem_req` and all ready pulses drop at once.
  - The FSM returns to IDLE and the in-flight transaction is lost.
  - Nothing is replayed after release.
- Latency, with the request first seen in IDLE at cycle 0:
  - `mem_req` goes high in cycle 1.
  - If `mem_ready` arrives in cycle 1+k, `x_ready` is high in cycle 2+k.
  - Minimum is 3 cycles from request to response (k=0).
- Throughput: at most one transaction per 3 cycles. No pipelining.
- Arbitration decisions happen only in IDLE. A grant is never pre-empted.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On simultaneous requests, grant the requester that did not win the previous grant. The last-grant bit resets to dcache, so icache wins the first tie.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, dcache over icache.
  - A continuously requesting dcache can starve the icache; this is accepted because dcache stalls block the pipeline.

## Test plan
- **Single icache read:** `i_addr`=0x00400004, `mem_ready` in cycle 1, `mem_rdata`=0x8C080000 -> `mem_addr`=0x00400004 and `mem_we`=0 in cycle 1; `i_ready`=1 with `i_rdata`=0x8C080000 in cycle 2 only.
- **Simultaneous requests:** `i_addr`=0x00400010 and `d_addr`=0x10010000 with `d_we`=0 in the same cycle.
  - Without the macro: dcache is served first, icache is granted in the IDLE after dcache's RESP.
  - With the macro after reset: icache is served first.
- **Dcache write with wait states:** `d_addr`=0x10010008, `d_wdata`=0xDEADBEEF, `mem_ready` after 3 MEM cycles -> `mem_we`=1 and `mem_wdata`=0xDEADBEEF held for all 4 MEM cycles; `d_ready` pulse with `d_rdata`=0.
- **Watchdog:** `TIMEOUT`=4, `mem_ready` held 0 -> `mem_req` drops after 4 MEM cycles; `i_ready` pulse with `i_rdata`=0; `err_timeout`=1 and still 1 after a later successful transaction.
- **Reset mid-MEM:** assert `reset`=0 in the second MEM cycle -> `mem_req`, `busy` and `err_timeout` go to 0 immediately; no ready pulse; after release with no requests, the block stays idle.
- **Unaligned address:** `d_addr`=0x00400007 -> `mem_addr`=0x00400004.
